avr_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for avr_cpu. It owns the program counter and drives a synchronous program memory with 1-cycle read latency.
- It presents complete instructions (opcode plus second word for two-word ops) to the core's instr input through a valid/stall handshake.
- It handles branch redirects, skip-next-instruction and back-pressure, and sits between program memory and the core's decode stage.

---
 rtl/avr_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_avr_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// avr_fetch_ctrl : AVR fetch sequencer -- PC, two-word assembly, skid, skip, branch
// Rev 1.0
// ============================================================================
module avr_fetch_ctrl #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [15:0]     pm_data,
  output logic [15:0]     instr,
  output logic [15:0]     instr_k,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            skip
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WORD2    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0]     op;
    logic [15:0]     k;
    logic [PC_W-1:0] pc;
  } entry_t;

  state_t          r_state, w_state_n;
  logic [PC_W-1:0] r_pc;
  logic            r_run;
  logic            r_ret_v;
  logic [PC_W-1:0] r_ret_pc;
  logic [15:0]     r_op;
  logic [PC_W-1:0] r_op_pc;
  entry_t          r_q0, r_q1;
  logic [1:0]      r_occ;
  logic            r_skip_pend;

  logic            w_two_word;
  logic            w_live_c;
  entry_t          w_live;
  logic            w_head_v;
  entry_t          w_head;
  logic            w_pop;
  logic            w_xfer;
  entry_t          w_q0_n, w_q1_n;
  logic [1:0]      w_occ_tmp, w_occ_n;

  assign w_two_word = ((pm_data & 16'hFE0C) == 16'h940C) ||
                      ((pm_data & 16'hFC0F) == 16'h9000);

  // A returning word completes an instruction unless it is the opcode of a two-word op.
  assign w_live_c = r_ret_v && ((r_state == WORD2) || ((r_state == FETCH) && !w_two_word));
  assign w_live   = (r_state == WORD2) ? '{op: r_op,    k: pm_data, pc: r_op_pc}
                                       : '{op: pm_data, k: 16'h0,   pc: r_ret_pc};

  // Hold/skid entries are older than the live return, so they are presented first.
  assign w_head_v    = (r_occ != 2'd0) || w_live_c;
  assign w_head      = (r_occ != 2'd0) ? r_q0 : w_live;
  assign instr_valid = w_head_v && !r_skip_pend;
  assign w_pop       = w_head_v && (r_skip_pend || !stall);
  assign w_xfer      = instr_valid && !stall;

  assign instr    = instr_valid ? w_head.op : 16'h0;
  assign instr_k  = instr_valid ? w_head.k  : 16'h0;
  assign instr_pc = instr_valid ? w_head.pc : '0;

  always_comb begin
    w_q0_n    = r_q0;
    w_q1_n    = r_q1;
    w_occ_tmp = r_occ;
    if (w_pop && (r_occ != 2'd0)) begin
      w_q0_n    = r_q1;
      w_occ_tmp = r_occ - 2'd1;
    end
    w_occ_n = w_occ_tmp;
    if (w_live_c && !(w_pop && (r_occ == 2'd0))) begin
      if (w_occ_tmp == 2'd0) w_q0_n = w_live;
      else                   w_q1_n = w_live;
      w_occ_n = w_occ_tmp + 2'd1;
    end
  end

  // A read issued now returns next cycle, so only issue if that return will have a slot.
  assign pm_rd   = r_run && (w_occ_n <= 2'd1);
  assign pm_addr = r_pc;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      FETCH:    if (r_ret_v && w_two_word) w_state_n = WORD2;
      WORD2:    w_state_n = FETCH;
      REDIRECT: w_state_n = FETCH;
      default:  w_state_n = FETCH;
    endcase
    if (br_valid) w_state_n = REDIRECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_VEC;
      r_run       <= 1'b0;
      r_ret_v     <= 1'b0;
      r_ret_pc    <= '0;
      r_op        <= 16'h0;
      r_op_pc     <= '0;
      r_q0        <= '0;
      r_q1        <= '0;
      r_occ       <= 2'd0;
      r_skip_pend <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_ret_v && (r_state == FETCH) && w_two_word) begin
        r_op    <= pm_data;
        r_op_pc <= r_ret_pc;
      end
      if (br_valid) begin
        // Clearing r_ret_v acts as the flush tag for the read still in flight.
        r_pc        <= br_target;
        r_ret_v     <= 1'b0;
        r_occ       <= 2'd0;
        r_skip_pend <= 1'b0;
      end else begin
        r_ret_v <= pm_rd;
        if (pm_rd) begin
          r_ret_pc <= r_pc;
          r_pc     <= r_pc + PC_W'(1);
        end
        r_q0  <= w_q0_n;
        r_q1  <= w_q1_n;
        r_occ <= w_occ_n;
        if (w_xfer && skip)                r_skip_pend <= 1'b1;
        else if (w_head_v && r_skip_pend)  r_skip_pend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avr_fetch_ctrl.sv
`default_nettype none
// Directed bench for avr_fetch_ctrl: a 16-bit PC instance plus a 4-bit PC instance for wrap.
module tb_avr_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] pm_addr, pm_data, instr, instr_k, instr_pc, br_target;
  logic        pm_rd, instr_valid, stall, br_valid, skip;

  logic [3:0]  pm_addr4, instr_pc4, br_target4;
  logic [15:0] pm_data4, instr4, instr_k4;
  logic        pm_rd4, instr_valid4, stall4, br_valid4, skip4;

  logic [15:0] mem  [0:255];
  logic [15:0] mem4 [0:15];

  int checks = 0;
  int errors = 0;

  always @(posedge clk) if (pm_rd)  pm_data  <= mem[pm_addr[7:0]];
  always @(posedge clk) if (pm_rd4) pm_data4 <= mem4[pm_addr4];

  avr_fetch_ctrl #(.PC_W(16), .RESET_VEC(16'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .pm_addr(pm_addr), .pm_rd(pm_rd), .pm_data(pm_data),
    .instr(instr), .instr_k(instr_k), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .stall(stall), .br_valid(br_valid), .br_target(br_target), .skip(skip)
  );

  avr_fetch_ctrl #(.PC_W(4), .RESET_VEC(4'h0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pm_addr(pm_addr4), .pm_rd(pm_rd4), .pm_data(pm_data4),
    .instr(instr4), .instr_k(instr_k4), .instr_pc(instr_pc4), .instr_valid(instr_valid4),
    .stall(stall4), .br_valid(br_valid4), .br_target(br_target4), .skip(skip4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first cycle whose pm_rd should be high.
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; skip = 1'b0; br_valid = 1'b0; br_valid4 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (pm_rd !== 1'b0) begin errors++; $display("FAIL reset pm_rd got %b want 0", pm_rd); end
    checks++; if (pm_addr !== 16'h0) begin errors++; $display("FAIL reset pm_addr got %h want 0000", pm_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr_valid got %b want 0", instr_valid); end
    checks++; if ({instr, instr_k, instr_pc} !== 48'h0) begin errors++; $display("FAIL reset instr/k/pc got %h %h %h want 0", instr, instr_k, instr_pc); end
    do_reset();
    #1;
    checks++; if (pm_rd !== 1'b1 || pm_addr !== 16'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL first_fetch got rd %b addr %h valid %b want 1 0000 0", pm_rd, pm_addr, instr_valid);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] ea [0:5];
    logic        ev [0:5];
    logic [15:0] ei [0:5];
    logic [15:0] ek [0:5];
    logic [15:0] ep [0:5];
    ea = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6};
    ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ei = '{16'h5021, 16'h5022, 16'h0000, 16'h0, 16'h940C, 16'h3333};
    ek = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0123, 16'h0};
    ep = '{16'h0, 16'h1, 16'h2, 16'h0, 16'h3, 16'h5};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      checks++; if (pm_rd !== 1'b1 || pm_addr !== ea[i]) begin
        errors++; $display("FAIL fetch_addr c%0d got rd %b addr %h want 1 %h", i + 2, pm_rd, pm_addr, ea[i]);
      end
      checks++; if (instr_valid !== ev[i]) begin
        errors++; $display("FAIL fetch_valid c%0d got %b want %b", i + 2, instr_valid, ev[i]);
      end
      if (ev[i]) begin
        checks++; if ({instr, instr_k, instr_pc} !== {ei[i], ek[i], ep[i]}) begin
          errors++; $display("FAIL fetch_instr c%0d got %h %h %h want %h %h %h", i + 2, instr, instr_k, instr_pc, ei[i], ek[i], ep[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] gi [0:3];
    logic [15:0] gk [0:3];
    logic [15:0] gp [0:3];
    logic [15:0] xi [0:3];
    logic [15:0] xk [0:3];
    logic [15:0] xp [0:3];
    int n;
    xi = '{16'h5021, 16'h5022, 16'h0000, 16'h940C};
    xk = '{16'h0, 16'h0, 16'h0, 16'h0123};
    xp = '{16'h0, 16'h1, 16'h2, 16'h3};
    for (int j = 0; j < 4; j++) begin gi[j] = 16'hDEAD; gk[j] = 16'hDEAD; gp[j] = 16'hDEAD; end
    do_reset();
    step(); stall = 1'b1; #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h5021 || instr_pc !== 16'h0) begin
      errors++; $display("FAIL stall_first got v %b %h pc %h want 1 5021 0000", instr_valid, instr, instr_pc);
    end
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h5021 || instr_pc !== 16'h0) begin
        errors++; $display("FAIL stall_hold c%0d got v %b %h pc %h want 1 5021 0000", c, instr_valid, instr, instr_pc);
      end
      checks++; if (pm_rd !== 1'b0) begin
        errors++; $display("FAIL stall_pm_rd c%0d got %b want 0", c, pm_rd);
      end
    end
    step(); stall = 1'b0; #1;
    n = 0;
    for (int c = 0; c < 10 && n < 4; c++) begin
      if (instr_valid === 1'b1) begin
        gi[n] = instr; gk[n] = instr_k; gp[n] = instr_pc; n++;
      end
      step(); #1;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL stall_drain got %0d transfers want 4", n); end
    for (int j = 0; j < 4; j++) begin
      checks++; if ({gi[j], gk[j], gp[j]} !== {xi[j], xk[j], xp[j]}) begin
        errors++; $display("FAIL stall_order #%0d got %h %h %h want %h %h %h", j, gi[j], gk[j], gp[j], xi[j], xk[j], xp[j]);
      end
    end
  endtask

  task automatic test_skip();
    do_reset();
    br_valid = 1'b1; br_target = 16'h0010;
    step(); br_valid = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0 || pm_rd !== 1'b1 || pm_addr !== 16'h0010) begin
      errors++; $display("FAIL skip_redirect got v %b rd %b addr %h want 0 1 0010", instr_valid, pm_rd, pm_addr);
    end
    step(); skip = 1'b1; #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h1001 || instr_pc !== 16'h0010) begin
      errors++; $display("FAIL skip_cpse got v %b %h pc %h want 1 1001 0010", instr_valid, instr, instr_pc);
    end
    step(); skip = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL skip_lds_op got valid %b want 0", instr_valid); end
    step(); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL skip_lds_k got valid %b instr %h want 0", instr_valid, instr); end
    step(); stall = 1'b1; skip = 1'b1; #1;
    checks++; if ({instr_valid, instr, instr_k, instr_pc} !== {1'b1, 16'hE8E0, 16'h0, 16'h0013}) begin
      errors++; $display("FAIL skip_next got v %b %h %h %h want 1 e8e0 0000 0013", instr_valid, instr, instr_k, instr_pc);
    end
    step(); stall = 1'b0; skip = 1'b0; #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0013) begin
      errors++; $display("FAIL skip_stall_hold got v %b pc %h want 1 0013", instr_valid, instr_pc);
    end
    step(); #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h2014 || instr_pc !== 16'h0014) begin
      errors++; $display("FAIL skip_ignored_on_stall got v %b %h pc %h want 1 2014 0014", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_branch();
    do_reset();
    br_valid = 1'b1; br_target = 16'h0030;
    step(); br_target = 16'h0020; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_first got valid %b want 0", instr_valid); end
    step(); br_valid = 1'b0; #1;
    checks++; if (pm_rd !== 1'b1 || pm_addr !== 16'h0020 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL br_last_wins got rd %b addr %h v %b want 1 0020 0", pm_rd, pm_addr, instr_valid);
    end
    step(); br_valid = 1'b1; br_target = 16'h0040; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_word2_op got valid %b want 0", instr_valid); end
    step(); br_valid = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0 || pm_addr !== 16'h0040 || pm_rd !== 1'b1) begin
      errors++; $display("FAIL br_flush got v %b instr %h addr %h rd %b want 0 - 0040 1", instr_valid, instr, pm_addr, pm_rd);
    end
    step(); #1;
    checks++; if ({instr_valid, instr, instr_k, instr_pc} !== {1'b1, 16'h2222, 16'h0, 16'h0040}) begin
      errors++; $display("FAIL br_target got v %b %h %h %h want 1 2222 0000 0040", instr_valid, instr, instr_k, instr_pc);
    end
    step(); #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h4141 || instr_pc !== 16'h0041) begin
      errors++; $display("FAIL br_follow got v %b %h pc %h want 1 4141 0041", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    br_valid4 = 1'b1; br_target4 = 4'hF;
    step(); br_valid4 = 1'b0; #1;
    checks++; if (pm_rd4 !== 1'b1 || pm_addr4 !== 4'hF) begin
      errors++; $display("FAIL wrap_target got rd %b addr %h want 1 f", pm_rd4, pm_addr4);
    end
    step(); #1;
    checks++; if (pm_rd4 !== 1'b1 || pm_addr4 !== 4'h0 || instr_valid4 !== 1'b0) begin
      errors++; $display("FAIL wrap_addr got rd %b addr %h v %b want 1 0 0", pm_rd4, pm_addr4, instr_valid4);
    end
    step(); #1;
    checks++; if ({instr_valid4, instr4, instr_k4, instr_pc4} !== {1'b1, 16'h940C, 16'h0BEE, 4'hF}) begin
      errors++; $display("FAIL wrap_two_word got v %b %h %h %h want 1 940c 0bee f", instr_valid4, instr4, instr_k4, instr_pc4);
    end
    step(); #1;
    checks++; if ({instr_valid4, instr4, instr_k4, instr_pc4} !== {1'b1, 16'h7001, 16'h0, 4'h1}) begin
      errors++; $display("FAIL wrap_next got v %b %h %h %h want 1 7001 0000 1", instr_valid4, instr4, instr_k4, instr_pc4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); stall = 1'b1;
    step();
    step(); #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h5021) begin
      errors++; $display("FAIL mid_pre got v %b %h want 1 5021", instr_valid, instr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({pm_rd, pm_addr, instr_valid} !== {1'b0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_ctrl got rd %b addr %h v %b want 0 0000 0", pm_rd, pm_addr, instr_valid);
    end
    checks++; if ({instr, instr_k, instr_pc} !== 48'h0) begin
      errors++; $display("FAIL mid_reset_instr got %h %h %h want 0", instr, instr_k, instr_pc);
    end
    checks++; if (instr_valid4 !== 1'b0 || pm_addr4 !== 4'h0 || pm_rd4 !== 1'b0) begin
      errors++; $display("FAIL mid_reset_dut4 got v %b addr %h rd %b want 0 0 0", instr_valid4, pm_addr4, pm_rd4);
    end
    stall = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step(); #1;
    checks++; if (pm_rd !== 1'b1 || pm_addr !== 16'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_restart got rd %b addr %h v %b want 1 0000 0", pm_rd, pm_addr, instr_valid);
    end
    step(); #1;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h5021 || instr_pc !== 16'h0) begin
      errors++; $display("FAIL mid_first_instr got v %b %h pc %h want 1 5021 0000", instr_valid, instr, instr_pc);
    end
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; skip = 1'b0; br_valid = 1'b0; br_target = 16'h0;
    stall4 = 1'b0; skip4 = 1'b0; br_valid4 = 1'b0; br_target4 = 4'h0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    for (int a = 0; a < 16; a++) mem4[a] = 16'h0;
    mem[0] = 16'h5021; mem[1] = 16'h5022; mem[2] = 16'h0000; mem[3] = 16'h940C;
    mem[4] = 16'h0123; mem[5] = 16'h3333; mem[6] = 16'h6666;
    mem[8'h10] = 16'h1001; mem[8'h11] = 16'h9000; mem[8'h12] = 16'h00FF;
    mem[8'h13] = 16'hE8E0; mem[8'h14] = 16'h2014;
    mem[8'h20] = 16'h940C; mem[8'h21] = 16'h1111; mem[8'h30] = 16'h3030;
    mem[8'h40] = 16'h2222; mem[8'h41] = 16'h4141;
    mem4[15] = 16'h940C; mem4[0] = 16'h0BEE; mem4[1] = 16'h7001;

    test_reset();
    test_fetch();
    test_stall();
    test_skip();
    test_branch();
    test_wrap();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
